// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic-array feeder blocks.
package tpu_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAST,
    ST_ISSUE,
    ST_FLUSH,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// Enable-gated delay line carrying a data word plus its valid bit.
module skew_line #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en) begin
      data_d[0] = din;
      vld_d[0]  = vin;
      for (int j = 1; j < STAGES; j++) begin
        data_d[j] = data_q[j-1];
        vld_d[j]  = vld_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < STAGES; j++) data_q[j] <= '0;
      vld_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign dout = data_q[STAGES-1];
  assign vout = vld_q[STAGES-1];

endmodule

// File: rtl/fifo_row_feeder.sv
// Pops LANES words per row vector from a FIFO and issues the vectors to the
// systolic array with lane i delayed by i beats, then flushes the skew.
module fifo_row_feeder
  import tpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   fifo_rempty,
  output logic                   fifo_rinc,
  input  logic [WIDTH-1:0]       fifo_rdata,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_lane_vld,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(LANES);

  feeder_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] slot_q [LANES];
  logic [WIDTH-1:0] slot_d [LANES];

  logic             issue;
  logic             beat;
  logic [CNT_W:0]   issued;
  logic             last_pop;

  assign issue     = (state_q == ST_ISSUE);
  assign out_vld   = issue || (state_q == ST_FLUSH);
  assign beat      = out_vld && out_rdy;
  assign fifo_rinc = (state_q == ST_FETCH) && !fifo_rempty;
  assign busy      = busy_q;
  assign done      = done_q;

  // Pops issued so far = words captured plus the one still in flight.
  assign issued   = {1'b0, word_cnt_q} + {{CNT_W{1'b0}}, pop_q};
  assign last_pop = fifo_rinc && (issued == (CNT_W+1)'(LANES-1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    vec_cnt_d   = vec_cnt_q;
    word_cnt_d  = word_cnt_q;
    flush_cnt_d = flush_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    slot_d      = slot_q;
    pop_d       = fifo_rinc;

    if (pop_q) begin
      slot_d[word_cnt_q] = fifo_rdata;
      word_cnt_d         = word_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d  = len;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            vec_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (last_pop) state_d = ST_LAST;
      end
      ST_LAST: begin
        word_cnt_d = '0;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (out_rdy) begin
          vec_cnt_d = vec_cnt_q + LEN_W'(1);
          if (vec_cnt_q == len_q - LEN_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FLUSH: begin
        if (out_rdy) begin
          if (flush_cnt_q == CNT_W'(LANES-2)) state_d = ST_DONE;
          else flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      vec_cnt_q   <= '0;
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
      pop_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      vec_cnt_q   <= vec_cnt_d;
      word_cnt_q  <= word_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pop_q       <= pop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      slot_q      <= slot_d;
    end
  end

  // Lane 0 is undelayed; lane i passes through an i-stage skew line.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign out_data[0 +: WIDTH] = issue ? slot_q[0] : '0;
      assign out_lane_vld[0]      = issue;
    end else begin : g_skew
      skew_line #(
        .WIDTH (WIDTH),
        .STAGES(i)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .en  (beat),
        .din (issue ? slot_q[i] : '0),
        .vin (issue),
        .dout(out_data[i*WIDTH +: WIDTH]),
        .vout(out_lane_vld[i])
      );
    end
  end

endmodule

// File: tb/tb_fifo_row_feeder.sv
// Directed bench for fifo_row_feeder with a FIFO model and a beat scoreboard.
module tb_fifo_row_feeder;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int LEN_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [LEN_W-1:0]       len;
  logic                   fifo_rempty;
  logic                   fifo_rinc;
  logic [WIDTH-1:0]       fifo_rdata = '0;
  logic                   out_vld;
  logic                   out_rdy;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_lane_vld;
  logic                   busy;
  logic                   done;

  fifo_row_feeder #(.WIDTH(WIDTH), .LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .fifo_rdata  (fifo_rdata),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_data    (out_data),
    .out_lane_vld(out_lane_vld),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read, empty when pointers meet.
  logic [WIDTH-1:0] mem [256];
  int rp = 0;
  int wp = 0;
  assign fifo_rempty = (rp == wp);
  always @(posedge clk) begin
    if (fifo_rinc && rp != wp) begin
      fifo_rdata <= mem[rp];
      rp         <= rp + 1;
    end
  end

  typedef struct packed {
    logic [LANES*WIDTH-1:0] d;
    logic [LANES-1:0]       v;
  } beat_t;
  beat_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int dones = 0;
  int beats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (fifo_rinc) pops++;
    if (done) dones++;
    if (out_vld && out_rdy) begin
      beats++;
      check("beat_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", out_data, e.d);
        check("beat_lane_vld", 32'(out_lane_vld), 32'(e.v));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n);
    for (int j = 0; j < n; j++) begin
      mem[wp] = WIDTH'(base + j);
      wp = wp + 1;
    end
  endtask

  // Beat k, lane i carries vector (k-i) lane i, word base + v*LANES + i.
  task automatic push_expect(input int base, input int n);
    beat_t e;
    for (int k = 0; k < n + LANES - 1; k++) begin
      e = '0;
      for (int i = 0; i < LANES; i++) begin
        if (k - i >= 0 && k - i < n) begin
          e.d[i*WIDTH +: WIDTH] = WIDTH'(base + (k - i) * LANES + i);
          e.v[i] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    int d0;
    c  = 0;
    d0 = dones;
    while (dones == d0 && c < budget) begin
      tick();
      c++;
    end
    check(tag, 32'(dones - d0), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rinc"}, 32'(fifo_rinc), 32'd0);
    check({tag, "_vld"}, 32'(out_vld), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_lane_vld"}, 32'(out_lane_vld), 32'd0);
  endtask

  initial begin
    int p0, d0, b0, c;
    rst     = 1'b1;
    start   = 1'b0;
    len     = '0;
    out_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // len=1, words 01..04
    p0 = pops; d0 = dones; b0 = beats;
    load(8'h01, 4);
    push_expect(8'h01, 1);
    pulse_start(1);
    check("busy_rise", 32'(busy), 32'd1);
    wait_done("len1_done", 60);
    tick();
    tick();
    check("len1_pops", 32'(pops - p0), 32'd4);
    check("len1_beats", 32'(beats - b0), 32'd4);
    check("len1_done_once", 32'(dones - d0), 32'd1);
    check("len1_sb_empty", 32'(exp_q.size()), 32'd0);
    check("len1_busy_low", 32'(busy), 32'd0);

    // len=2, words 10..17, with a start pulse mid-job that must be ignored
    p0 = pops; b0 = beats;
    load(8'h10, 8);
    push_expect(8'h10, 2);
    pulse_start(2);
    tick();
    tick();
    tick();
    pulse_start(7);
    wait_done("len2_done", 80);
    tick();
    tick();
    check("len2_pops", 32'(pops - p0), 32'd8);
    check("len2_beats", 32'(beats - b0), 32'd5);
    check("len2_sb_empty", 32'(exp_q.size()), 32'd0);
    check("len2_busy_low", 32'(busy), 32'd0);

    // FIFO runs dry after two words for five cycles
    p0 = pops;
    load(8'h20, 2);
    push_expect(8'h20, 1);
    pulse_start(1);
    c = 0;
    while (pops - p0 < 2 && c < 20) begin
      tick();
      c++;
    end
    check("gap_two_pops", 32'(pops - p0), 32'd2);
    for (int g = 0; g < 5; g++) begin
      tick();
      check("gap_rinc_low", 32'(fifo_rinc), 32'd0);
    end
    check("gap_no_pops", 32'(pops - p0), 32'd2);
    load(8'h22, 2);
    wait_done("gap_done", 60);
    check("gap_pops", 32'(pops - p0), 32'd4);
    check("gap_sb_empty", 32'(exp_q.size()), 32'd0);

    // out_rdy low for three cycles in FLUSH
    b0 = beats;
    load(8'h30, 4);
    push_expect(8'h30, 1);
    pulse_start(1);
    c = 0;
    while (beats - b0 < 2 && c < 40) begin
      tick();
      c++;
    end
    out_rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_vld", 32'(out_vld), 32'd1);
      if (exp_q.size() != 0) begin
        check("stall_data", out_data, exp_q[0].d);
        check("stall_lane_vld", 32'(out_lane_vld), 32'(exp_q[0].v));
      end
    end
    check("stall_beats", 32'(beats - b0), 32'd2);
    out_rdy = 1'b1;
    wait_done("stall_done", 40);
    check("stall_total_beats", 32'(beats - b0), 32'd4);
    check("stall_sb_empty", 32'(exp_q.size()), 32'd0);

    // len=0: done two cycles after start, start during busy ignored
    p0 = pops; d0 = dones;
    start = 1'b1;
    len   = '0;
    tick();
    check("len0_busy", 32'(busy), 32'd1);
    check("len0_done_early", 32'(done), 32'd0);
    start = 1'b1;
    len   = LEN_W'(5);
    tick();
    start = 1'b0;
    len   = '0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy_drop", 32'(busy), 32'd0);
    tick();
    check("len0_done_pulse", 32'(done), 32'd0);
    tick();
    tick();
    tick();
    check("len0_pops", 32'(pops - p0), 32'd0);
    check("len0_idle", 32'(busy), 32'd0);
    check("len0_done_count", 32'(dones - d0), 32'd1);

    // asynchronous reset while a vector waits in ISSUE
    load(8'h40, 4);
    out_rdy = 1'b0;
    pulse_start(1);
    c = 0;
    while (!out_vld && c < 30) begin
      tick();
      c++;
    end
    check("rst_reached_issue", 32'(out_vld), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    exp_q.delete();
    tick();
    rst     = 1'b0;
    out_rdy = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    p0 = pops; b0 = beats;
    load(8'h50, 4);
    push_expect(8'h50, 1);
    pulse_start(1);
    wait_done("post_rst_done", 60);
    check("post_rst_pops", 32'(pops - p0), 32'd4);
    check("post_rst_beats", 32'(beats - b0), 32'd4);
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_row_feeder.md
# fifo_row_feeder

Drains an upstream `sfifo` one word at a time and assembles `LANES` consecutive words into one row vector. Issues each vector to the systolic array with the diagonal skew the array needs: lane i is delayed by i beats. Sits between the activation/weight FIFO and the PE array's west edge. After the last vector it flushes the skew pipeline and pulses `done`.

## Interface
Parameters:
- `WIDTH`, 8, bits per FIFO word / per lane
- `LANES`, 4, lanes per row vector (≥2); also skew depth + 1
- `LEN_W`, 16, width of the vector-count input

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a job; sampled only in IDLE
- `len`  in  LEN_W  number of row vectors in the job; sampled with `start`
- `fifo_rempty`  in  1  FIFO empty flag
- `fifo_rinc`  out  1  FIFO pop request
- `fifo_rdata`  in  WIDTH  FIFO read data, valid the cycle after a pop
- `out_vld`  out  1  a skew beat is presented
- `out_rdy`  in  1  array accepts the beat
- `out_data`  out  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- `out_lane_vld`  out  LANES  bit i set when lane i carries real data
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse at job end

## Operation
- FSM states: IDLE, FETCH, LAST, ISSUE, FLUSH, DONE.
- IDLE: when `start`=1, latch `len`.
  - `len`=0: go to DONE with no pops.
  - Otherwise: clear `vec_cnt` and `word_cnt`, go to FETCH.
- FETCH: `fifo_rinc` = !`fifo_rempty`.
  - Each pop captures `fifo_rdata` one cycle later into slot `word_cnt`, then increments `word_cnt`.
  - Pops stall whenever `rempty`=1; there is no timeout.
  - After the LANES-th pop, go to LAST with `fifo_rinc`=0.
- LAST: captures the final word, then goes to ISSUE.
- ISSUE: `out_vld`=1. A beat = `out_vld`&&`out_rdy`.
  - On a beat, the skew lines shift and assembled vector lane i enters skew line i.
  - Increment `vec_cnt`. If `vec_cnt`==len-1, go to FLUSH; otherwise go to FETCH.
  - When `out_rdy`=0, `out_data`, `out_lane_vld` and `out_vld` hold exactly.
- FLUSH: `out_vld`=1 for LANES-1 beats. Zeros with cleared valid bits are injected at every lane input. Then go to DONE.
- DONE: `done`=1 for one cycle, `busy` drops in the same cycle, then go to IDLE.
- Skew line i holds i registers; lane 0 has no register. Each register stage advances only on a beat.
  - Lane i on beat k carries vector (k−i) lane i when 0 ≤ k−i < len; otherwise it carries 0 with `out_lane_vld[i]`=0.
  - Lane 0 is driven combinationally from the assembled vector during ISSUE and is 0 during FLUSH.
- `start` while `busy` is ignored; `len` is not re-sampled.
- Width rules:
  - `word_cnt` is $clog2(LANES) bits.
  - `vec_cnt` is LEN_W bits and compares against latched `len`−1. `len`=0 never reaches the compare.

## Timing
- Reset (async assert, sync release): state=IDLE, all counters, slots and skew registers 0.
  - Outputs: `fifo_rinc`, `out_vld`, `busy`, `done` = 0; `out_data`=0; `out_lane_vld`=0.
- Reset mid-job abandons the job. Words already popped are lost; no `done` is issued.
- FIFO read latency is fixed at 1 cycle (registered RAM read). `fifo_rempty` is registered in the FIFO and can lag one cycle; the feeder honours it as given.
- Best-case throughput: one vector per LANES+2 cycles (LANES pops, LAST, ISSUE beat).
- A beat is the only event that advances the skew pipeline.
- `busy` rises the cycle after `start` is accepted.

## Structure
- Shared package `tpu_pkg`:
  - FSM state enum `feeder_state_t`
  - default `LANES`/`WIDTH` localparams
- Sub-module `skew_line` (parameters `WIDTH`, `STAGES`): enable-gated shift register carrying data plus a valid bit; instantiated once per lane i≥1 with STAGES=i.

## Test plan
- Async reset during ISSUE -> all outputs 0 immediately; IDLE on release; a following `start` runs a clean job.
- LANES=4, FIFO holds 0x01..0x04, `len`=1, `out_rdy`=1:
  - exactly 4 `fifo_rinc` pulses
  - beats: lane0=01 vld=0001; lane1=02 vld=0010; lane2=03 vld=0100; lane3=04 vld=1000
  - then `done` one cycle
- `len`=2, FIFO 0x10..0x17 -> beat1 lane0=0x14 and lane1=0x11 with vld=0011; 5 beats total; `done` after the last.
- FIFO empties after 2 of 4 words for 5 cycles -> `fifo_rinc`=0 during the gap; resumes; vector content unchanged; no extra pops.
- `out_rdy`=0 for 3 cycles mid-FLUSH -> `out_data`/`out_lane_vld` held; beat count unchanged.
- `len`=0 -> `done` two cycles after `start`, zero pops; `start` pulsed while `busy` -> ignored.
